// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared register offsets and constants for the board input port
package io_port_pkg;

  // Register offsets on the CPU load/store bus
  localparam logic [2:0] OFS_SW_LO = 3'd0;
  localparam logic [2:0] OFS_SW_HI = 3'd1;
  localparam logic [2:0] OFS_KEY   = 3'd2;
  localparam logic [2:0] OFS_EDGE  = 3'd3;
  localparam logic [2:0] OFS_MASK  = 3'd4;

  // Push buttons are active-low; idle level is high
  localparam logic KEY_RELEASED = 1'b1;

  localparam int NUM_SW  = 10;
  localparam int NUM_KEY = 4;

  typedef logic [NUM_KEY-1:0] key_vec_t;
  typedef logic [NUM_SW-1:0]  sw_vec_t;

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - single-bit 2-flop synchroniser followed by a counting debouncer
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_deb,
  output logic o_deb_next
);

  localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_deb;
  logic [7:0] r_cnt;

  logic       w_differ;
  logic       w_flip;

  assign w_differ = (r_sync2 != r_deb);
  // The debounced level follows only after DEBOUNCE_CYCLES consecutive disagreeing samples
  assign w_flip   = w_differ && (r_cnt == LAST_COUNT);

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
      r_deb <= RESET_VAL;
    end else if (!w_differ) begin
      r_cnt <= 8'd0;
    end else if (w_flip) begin
      r_cnt <= 8'd0;
      r_deb <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_deb      = r_deb;
  // Level the debounced flop takes at the coming edge, used for same-edge press capture
  assign o_deb_next = w_flip ? r_sync2 : r_deb;

endmodule

// File: rtl/input_port_ctrl.sv
// rtl/input_port_ctrl.sv - memory-mapped SW/KEY input peripheral with press capture and irq
module input_port_ctrl
  import io_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            sw_in,
  input  logic [3:0]            key_in,
  input  logic [2:0]            addr,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  irq
);

  sw_vec_t  w_sw_deb;
  sw_vec_t  w_sw_deb_next;
  key_vec_t w_key_deb;
  key_vec_t w_key_deb_next;
  key_vec_t w_press;
  key_vec_t w_w1c;
  logic [7:0] w_rd_byte;
  logic       w_unused;

  key_vec_t r_edge_cap;
  key_vec_t r_irq_mask;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    input_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0)
    ) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_pin      (sw_in[g]),
      .o_deb      (w_sw_deb[g]),
      .o_deb_next (w_sw_deb_next[g])
    );
  end

  for (genvar g = 0; g < NUM_KEY; g++) begin : g_key
    input_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (KEY_RELEASED)
    ) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_pin      (key_in[g]),
      .o_deb      (w_key_deb[g]),
      .o_deb_next (w_key_deb_next[g])
    );
  end

  // A press is the debounced key falling 1->0 on this edge
  assign w_press = w_key_deb & ~w_key_deb_next;
  assign w_w1c   = (wr_en && (addr == OFS_EDGE)) ? wr_data[3:0] : '0;

  // Upper write bits and the SW look-ahead have no function here
  assign w_unused = ^{wr_data[DATA_WIDTH-1:4], w_sw_deb_next};

  // Press capture with write-one-to-clear; a same-edge press overrides the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cap <= '0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_w1c) | w_press;
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_mask <= '0;
    end else if (wr_en && (addr == OFS_MASK)) begin
      r_irq_mask <= wr_data[3:0];
    end
  end

  // Registered level interrupt from the current capture and mask state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(r_edge_cap & r_irq_mask);
    end
  end

  // Read decode from pre-edge register state, so a concurrent write is not seen
  always_comb begin
    w_rd_byte = 8'h00;
    case (addr)
      OFS_SW_LO: w_rd_byte = w_sw_deb[7:0];
      OFS_SW_HI: w_rd_byte = {6'd0, w_sw_deb[9:8]};
      OFS_KEY:   w_rd_byte = {4'd0, w_key_deb};
      OFS_EDGE:  w_rd_byte = {4'd0, r_edge_cap};
      OFS_MASK:  w_rd_byte = {4'd0, r_irq_mask};
      default:   w_rd_byte = 8'h00;
    endcase
  end

  // Read data holds between reads; valid pulses for each sampled read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= DATA_WIDTH'(w_rd_byte);
      end
    end
  end

endmodule

// File: tb/tb_input_port_ctrl.sv
// tb/tb_input_port_ctrl.sv - self-checking bench for input_port_ctrl
module tb_input_port_ctrl;

  localparam int D  = 4;
  localparam int DW = 8;
  localparam logic [13:0] PIN_RESET = 14'h3C00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    sw_in = '0;
  logic [3:0]    key_in = 4'hF;
  logic [2:0]    addr = '0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          irq;

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  input_port_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_in    (sw_in),
    .key_in   (key_in),
    .addr     (addr),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: pins delayed two edges, then a level is adopted once the last D
  // synchronised samples all disagree with it. Bits [9:0]=SW, [13:10]=KEY.
  logic [13:0] m_p1, m_p2, m_deb;
  logic [13:0] m_win [D];
  logic [3:0]  m_cap, m_mask;
  logic        m_irq, m_valid;
  logic [7:0]  m_rdata;

  function automatic logic [7:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0:    return m_deb[7:0];
      3'd1:    return {6'd0, m_deb[9:8]};
      3'd2:    return {4'd0, m_deb[13:10]};
      3'd3:    return {4'd0, m_cap};
      3'd4:    return {4'd0, m_mask};
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_p1 = PIN_RESET; m_p2 = PIN_RESET; m_deb = PIN_RESET;
      for (int i = 0; i < D; i++) m_win[i] = PIN_RESET;
      m_cap = '0; m_mask = '0; m_irq = 1'b0; m_valid = 1'b0; m_rdata = '0;
    end else begin
      logic [13:0] sync_v, flip, nd;
      logic [3:0]  press;
      sync_v = m_p2;
      m_p2 = m_p1;
      m_p1 = {key_in, sw_in};
      for (int i = D - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = sync_v;
      flip = '1;
      for (int i = 0; i < D; i++) flip &= (m_win[i] ^ m_deb);
      nd = m_deb ^ flip;
      press = m_deb[13:10] & ~nd[13:10];
      if (rd_en) m_rdata = m_reg(addr);
      m_valid = rd_en;
      m_irq = |(m_cap & m_mask);
      if (wr_en && addr == 3'd3) m_cap &= ~wr_data[3:0];
      if (wr_en && addr == 3'd4) m_mask = wr_data[3:0];
      m_cap |= press;
      m_deb = nd;
    end
    #1;
    if (cmp_on) begin
      chk("cyc_rd_valid", rd_valid, m_valid);
      chk("cyc_rd_data", rd_data, m_rdata);
      chk("cyc_irq", irq, m_irq);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk(name, rd_data, exp);
    chk({name, "_valid"}, rd_valid, 1'b1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    tick(3);
    cmp_on = 1'b1;
    chk("rst_irq", irq, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    rst_n = 1'b1;
    tick(8);
    rd(3'd0, 8'h00, "rst_sw_lo");
    rd(3'd1, 8'h00, "rst_sw_hi");
    rd(3'd2, 8'h0F, "rst_key");
    rd(3'd3, 8'h00, "rst_edge");
    rd(3'd4, 8'h00, "rst_mask");
    tick(1);
    chk("valid_drop", rd_valid, 1'b0);

    // SW change: debounced value lands on edge 6, a read sampled there sees the old value
    sw_in = 10'h1A5;
    tick(5);
    rd_en = 1'b1; addr = 3'd0;
    @(negedge clk);
    chk("sw_early", rd_data, 8'h00);
    @(negedge clk);
    rd_en = 1'b0;
    chk("sw_lo", rd_data, 8'hA5);
    chk("sw_b2b_valid", rd_valid, 1'b1);
    rd(3'd1, 8'h01, "sw_hi");
    tick(3);
    chk("rd_hold", rd_data, 8'h01);

    // Glitch of two cycles on SW[8] never reaches the debounced value
    sw_in = 10'h000;
    tick(8);
    rd(3'd1, 8'h00, "pre_glitch");
    sw_in[8] = 1'b1;
    rd(3'd1, 8'h00, "glitch_hi0");
    rd(3'd1, 8'h00, "glitch_hi1");
    sw_in[8] = 1'b0;
    for (int i = 0; i < 8; i++) rd(3'd1, 8'h00, "glitch_after");

    // Press capture and interrupt
    wr(3'd4, 8'h02);
    key_in[1] = 1'b0;
    tick(6);
    chk("irq_before", irq, 1'b0);
    rd(3'd3, 8'h02, "cap_set");
    chk("irq_set", irq, 1'b1);
    wr(3'd3, 8'h02);
    rd(3'd3, 8'h00, "cap_clr");
    chk("irq_clr", irq, 1'b0);
    key_in[1] = 1'b1;
    tick(8);
    rd(3'd3, 8'h00, "cap_release");
    key_in[1] = 1'b0;
    tick(7);
    rd(3'd3, 8'h02, "cap_repress");

    // Set/clear collision on KEY[0] with a concurrent read
    wr(3'd3, 8'h0F);
    tick(1);
    key_in[0] = 1'b0;
    tick(5);
    wr_en = 1'b1; rd_en = 1'b1; addr = 3'd3; wr_data = 8'h01;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("coll_rd_pre", rd_data, 8'h00);
    rd(3'd3, 8'h01, "coll_set_wins");
    wr_en = 1'b1; rd_en = 1'b1; addr = 3'd3; wr_data = 8'h01;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_pre_value", rd_data, 8'h01);
    rd(3'd3, 8'h00, "rw_post");
    key_in = 4'hF;
    tick(8);
    rd(3'd2, 8'h0F, "key_released");

    // Unmapped offsets
    wr(3'd4, 8'h05);
    rd(3'd5, 8'h00, "unmapped5");
    rd(3'd6, 8'h00, "unmapped6");
    rd(3'd7, 8'h00, "unmapped7");
    wr(3'd5, 8'hFF);
    wr(3'd6, 8'hFF);
    wr(3'd7, 8'hFF);
    rd(3'd4, 8'h05, "mask_kept");
    rd(3'd3, 8'h00, "edge_kept");
    rd(3'd0, 8'h00, "sw_kept");

    // Reset two cycles into a debounce discards the partial count
    sw_in = 10'h0FF;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int j = 1; j <= 7; j++) rd(3'd0, (j == 7) ? 8'hFF : 8'h00, "rst_mid_sw");
    rd(3'd4, 8'h00, "rst_mid_mask");

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
